// File: rtl/wave_gen_param.sv
// Phase-accumulator waveform generator with eight modes; mode switches only at period wrap.
// Optional output amplitude scaling is enabled by defining WAVE_AMP_SCALE_EN.
module wave_gen_param #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           slc,
  input  logic [ACC_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]     duty,
  input  logic [WIDTH-1:0]     amp,
  output logic [WIDTH-1:0]     out,
  output logic                 wrap,
  output logic [2:0]           mode
);

  typedef enum logic [2:0] {
    MODE_SAW_UP   = 3'b000,
    MODE_SAW_DOWN = 3'b001,
    MODE_TRIANGLE = 3'b010,
    MODE_SQUARE   = 3'b011,
    MODE_PULSE    = 3'b100,
    MODE_STAIR    = 3'b101,
    MODE_NOISE    = 3'b110,
    MODE_MID      = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] MAX_VAL    = '1;
  localparam logic [WIDTH-1:0] MID_VAL    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] STAIR_MASK = MAX_VAL << (WIDTH-3);

  logic [ACC_WIDTH-1:0] phase;
  logic [15:0]          lfsr;
  logic [ACC_WIDTH:0]   sum;
  logic [WIDTH-1:0]     idx;
  logic [WIDTH-1:0]     tri_t;
  logic                 lfsr_fb;
  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     sample;

  assign sum     = {1'b0, phase} + {1'b0, step};
  assign idx     = phase[ACC_WIDTH-1 -: WIDTH];
  assign tri_t   = {idx[WIDTH-2:0], 1'b0};
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    raw = '0;
    case (mode_t'(mode))
      MODE_SAW_UP:   raw = idx;
      MODE_SAW_DOWN: raw = MAX_VAL - idx;
      MODE_TRIANGLE: raw = idx[WIDTH-1] ? (MAX_VAL - tri_t) : tri_t;
      MODE_SQUARE:   raw = idx[WIDTH-1] ? MAX_VAL : '0;
      MODE_PULSE:    raw = (idx < duty) ? MAX_VAL : '0;
      MODE_STAIR:    raw = idx & STAIR_MASK;
      MODE_NOISE:    raw = lfsr[15 -: WIDTH];
      MODE_MID:      raw = MID_VAL;
      default:       raw = '0;
    endcase
  end

`ifdef WAVE_AMP_SCALE_EN
  // amp+1 lets amp=MAX pass the raw sample through unchanged
  logic [2*WIDTH:0] prod;
  assign prod   = (2*WIDTH+1)'(raw) * (2*WIDTH+1)'({1'b0, amp} + (WIDTH+1)'(1));
  assign sample = WIDTH'(prod >> WIDTH);
`else
  logic unused_amp;
  assign unused_amp = ^amp;
  assign sample     = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= '0;
      out   <= '0;
      wrap  <= 1'b0;
      lfsr  <= 16'hFFFF;
      mode  <= slc;
    end else if (en) begin
      phase <= sum[ACC_WIDTH-1:0];
      wrap  <= sum[ACC_WIDTH];
      if (sum[ACC_WIDTH]) mode <= slc;
      lfsr  <= {lfsr[14:0], lfsr_fb};
      out   <= sample;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule
